arith_wb_buffer: RTL and testbench

Writeback buffer on the result side of the arithmetic functional unit. Captures every registered FU result (the FU has no backpressure), queues it in a small in-order FIFO, and presents it to the common data bus (CDB) arbiter with a valid/grant handshake. Throttles the issue stage early enough that the FU's one-cycle pipeline can never overflow the queue, and drops everything on a pipeline flush.

---
 rtl/arith_wb_buffer_pkg.sv | 24 ++
 rtl/arith_wb_buffer_if.sv | 39 +++
 rtl/arith_wb_buffer_wb_sync_fifo.sv | 50 +++++
 rtl/arith_wb_buffer.sv | 72 +++++++
 tb/tb_arith_wb_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_wb_buffer_pkg.sv
// Shared definitions for the arithmetic FU writeback path: default sizes,
// tag widths and the queued entry layout used by the FU and CDB arbiter.
package arith_wb_buffer_pkg;

  localparam int DEF_XLEN          = 32;
  localparam int DEF_ROB_SIZE      = 256;
  localparam int DEF_PHYS_REG_SIZE = 256;
  localparam int DEF_DEPTH         = 4;

  // Tag width for a table of n entries; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ROB_W  = tag_w(DEF_ROB_SIZE);
  localparam int DEST_W = tag_w(DEF_PHYS_REG_SIZE);

  typedef struct packed {
    logic [DEF_XLEN-1:0] result;
    logic [ROB_W-1:0]    rob_entry;
    logic [DEST_W-1:0]   dest_reg;
  } wb_entry_t;

endpackage

// File: rtl/arith_wb_buffer_if.sv
// Bundle between the FU/issue/CDB side and the writeback buffer.
// Handshake: the buffer offers its head whenever cdb_valid=1 and holds every
// cdb_* field stable until a cycle with cdb_valid=1 and cdb_grant=1; that
// cycle is the transfer. cdb_grant with cdb_valid=0 means nothing. The FU side
// has no ready: fu_valid is a push that must be taken, issue_stall is the
// early throttle that keeps it from arriving at a full queue. count is a
// debug view of the queue occupancy.
interface arith_wb_buffer_if #(
  parameter int XLEN   = 32,
  parameter int ROB_W  = 8,
  parameter int DEST_W = 8,
  parameter int CW     = 3
);
  logic              flush;
  logic              fu_valid;
  logic [XLEN-1:0]   fu_result;
  logic [ROB_W-1:0]  fu_rob_entry;
  logic [DEST_W-1:0] fu_dest_reg;
  logic              cdb_valid;
  logic              cdb_grant;
  logic [XLEN-1:0]   cdb_result;
  logic [ROB_W-1:0]  cdb_rob_entry;
  logic [DEST_W-1:0] cdb_dest_reg;
  logic              issue_stall;
  logic              overflow;
  logic [CW-1:0]     count;

  modport slave (
    input  flush, fu_valid, fu_result, fu_rob_entry, fu_dest_reg, cdb_grant,
    output cdb_valid, cdb_result, cdb_rob_entry, cdb_dest_reg, issue_stall,
           overflow, count
  );

  modport master (
    output flush, fu_valid, fu_result, fu_rob_entry, fu_dest_reg, cdb_grant,
    input  cdb_valid, cdb_result, cdb_rob_entry, cdb_dest_reg, issue_stall,
           overflow, count
  );
endinterface

// File: rtl/arith_wb_buffer_wb_sync_fifo.sv
// Small in-order FIFO with wrapping pointers and a synchronous clear.
// The caller guarantees push is only raised when there is room (or a pop in
// the same cycle frees it).
module wb_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  // Storage write at the tail; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[head];

endmodule

// File: rtl/arith_wb_buffer.sv
// Writeback buffer between the arithmetic FU and the CDB arbiter. Queues
// every FU result in arrival order, offers the head to the CDB, throttles
// issue one entry early, drops everything on flush and flags a lost result.
module arith_wb_buffer
  import arith_wb_buffer_pkg::*;
#(
  parameter int XLEN          = DEF_XLEN,
  parameter int ROB_SIZE      = DEF_ROB_SIZE,
  parameter int PHYS_REG_SIZE = DEF_PHYS_REG_SIZE,
  parameter int DEPTH         = DEF_DEPTH
) (
  input logic                clk,
  input logic                rst,
  arith_wb_buffer_if.slave   bus
);
  localparam int RW = tag_w(ROB_SIZE);
  localparam int DW = tag_w(PHYS_REG_SIZE);
  localparam int EW = XLEN + RW + DW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0] din;
  logic [EW-1:0] dout;
  logic [CW-1:0] count;
  logic          full;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic          lost;
  logic          overflow_q;

  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  // A flush cancels both sides of the queue in the same cycle.
  assign pop       = not_empty && bus.cdb_grant && !bus.flush;
  // A full queue still accepts a result when the head leaves that cycle.
  assign push      = bus.fu_valid && !bus.flush && (!full || pop);
  assign lost      = bus.fu_valid && !bus.flush && full && !pop;
  assign din       = {bus.fu_result, bus.fu_rob_entry, bus.fu_dest_reg};

  wb_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  // Sticky record of a discarded result; only reset clears it, not flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (lost) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.cdb_valid = not_empty;
  assign {bus.cdb_result, bus.cdb_rob_entry, bus.cdb_dest_reg} =
      not_empty ? dout : '0;
  // One slot of headroom covers the result of a dispatch already in flight.
  assign bus.issue_stall = (count >= CW'(DEPTH - 1));
  assign bus.overflow    = overflow_q;
  assign bus.count       = count;

endmodule

// File: tb/tb_arith_wb_buffer.sv
// Bench for arith_wb_buffer: directed table of the main scenarios, then
// wrap-around and randomized traffic checked against a queue-based model.
module tb_arith_wb_buffer;
  import arith_wb_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  arith_wb_buffer_if #(.XLEN(32), .ROB_W(8), .DEST_W(8), .CW(3)) bus ();

  arith_wb_buffer #(
    .XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // reference model: arrival-ordered queue plus sticky overflow flag
  wb_entry_t model_q[$];
  logic      model_ov;

  typedef struct {
    logic        fv;
    logic [31:0] res;
    logic [7:0]  rob;
    logic [7:0]  dst;
    logic        g;
    logic        fl;
    logic        rs;
    logic        ev;
    logic [31:0] eres;
    logic [7:0]  erob;
    logic [7:0]  edst;
    logic [2:0]  ecnt;
    logic        est;
    logic        eov;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(
    input logic fv, input logic [31:0] res, input logic [7:0] rob,
    input logic [7:0] dst, input logic g, input logic fl, input logic rs,
    input logic ev, input logic [31:0] eres, input logic [7:0] erob,
    input logic [7:0] edst, input logic [2:0] ecnt, input logic est,
    input logic eov);
    vec_t v;
    v.fv = fv; v.res = res; v.rob = rob; v.dst = dst; v.g = g; v.fl = fl;
    v.rs = rs; v.ev = ev; v.eres = eres; v.erob = erob; v.edst = edst;
    v.ecnt = ecnt; v.est = est; v.eov = eov;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic apply(input logic fv, input logic [31:0] res,
                       input logic [7:0] rob, input logic [7:0] dst,
                       input logic g, input logic fl, input logic rs);
    bus.fu_valid     = fv;
    bus.fu_result    = res;
    bus.fu_rob_entry = rob;
    bus.fu_dest_reg  = dst;
    bus.cdb_grant    = g;
    bus.flush        = fl;
    rst              = rs;
  endtask

  // advance the model by one clock edge with the given inputs
  task automatic model_step(input logic fv, input wb_entry_t e,
                            input logic g, input logic fl, input logic rs);
    bit popd;
    bit drop;
    if (rs) begin
      model_q.delete();
      model_ov = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      popd = g && (model_q.size() != 0);
      drop = fv && (model_q.size() == DEPTH) && !popd;
      if (drop) model_ov = 1'b1;
      if (popd) void'(model_q.pop_front());
      if (fv && !drop) model_q.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    wb_entry_t e;
    logic      ev;
    ev = (model_q.size() != 0);
    e  = ev ? model_q[0] : '0;
    check({tag, ".valid"}, 64'(bus.cdb_valid), 64'(ev));
    check({tag, ".result"}, 64'(bus.cdb_result), 64'(e.result));
    check({tag, ".rob"}, 64'(bus.cdb_rob_entry), 64'(e.rob_entry));
    check({tag, ".dest"}, 64'(bus.cdb_dest_reg), 64'(e.dest_reg));
    check({tag, ".count"}, 64'(bus.count), 64'(model_q.size()));
    check({tag, ".stall"}, 64'(bus.issue_stall),
          64'(model_q.size() >= DEPTH - 1));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(model_ov));
  endtask

  // driver: one cycle of stimulus, model update, then check after the edge
  task automatic drive_cycle(input string tag, input logic fv,
                             input logic [31:0] res, input logic [7:0] rob,
                             input logic [7:0] dst, input logic g,
                             input logic fl, input logic rs);
    wb_entry_t e;
    e.result = res; e.rob_entry = rob; e.dest_reg = dst;
    apply(fv, res, rob, dst, g, fl, rs);
    @(posedge clk);
    model_step(fv, e, g, fl, rs);
    #1;
    check_model(tag);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    model_ov = 1'b0;

    // directed table: single result, backpressure, full push+pop,
    // overflow, reset, flush
    vecs[0]  = mk(1, 7,  5,  12,  1, 0, 0,  1, 7,  5,  12,  1, 0, 0);
    vecs[1]  = mk(0, 0,  0,  0,   1, 0, 0,  0, 0,  0,  0,   0, 0, 0);
    vecs[2]  = mk(1, 1,  1,  101, 0, 0, 0,  1, 1,  1,  101, 1, 0, 0);
    vecs[3]  = mk(1, 2,  2,  102, 0, 0, 0,  1, 1,  1,  101, 2, 0, 0);
    vecs[4]  = mk(1, 3,  3,  103, 0, 0, 0,  1, 1,  1,  101, 3, 1, 0);
    vecs[5]  = mk(0, 0,  0,  0,   0, 0, 0,  1, 1,  1,  101, 3, 1, 0);
    vecs[6]  = mk(0, 0,  0,  0,   1, 0, 0,  1, 2,  2,  102, 2, 0, 0);
    vecs[7]  = mk(0, 0,  0,  0,   1, 0, 0,  1, 3,  3,  103, 1, 0, 0);
    vecs[8]  = mk(0, 0,  0,  0,   1, 0, 0,  0, 0,  0,  0,   0, 0, 0);
    vecs[9]  = mk(1, 10, 10, 110, 0, 0, 0,  1, 10, 10, 110, 1, 0, 0);
    vecs[10] = mk(1, 11, 11, 111, 0, 0, 0,  1, 10, 10, 110, 2, 0, 0);
    vecs[11] = mk(1, 12, 12, 112, 0, 0, 0,  1, 10, 10, 110, 3, 1, 0);
    vecs[12] = mk(1, 13, 13, 113, 0, 0, 0,  1, 10, 10, 110, 4, 1, 0);
    vecs[13] = mk(1, 14, 14, 114, 1, 0, 0,  1, 11, 11, 111, 4, 1, 0);
    vecs[14] = mk(0, 0,  0,  0,   1, 0, 0,  1, 12, 12, 112, 3, 1, 0);
    vecs[15] = mk(0, 0,  0,  0,   1, 0, 0,  1, 13, 13, 113, 2, 0, 0);
    vecs[16] = mk(0, 0,  0,  0,   1, 0, 0,  1, 14, 14, 114, 1, 0, 0);
    vecs[17] = mk(0, 0,  0,  0,   1, 0, 0,  0, 0,  0,  0,   0, 0, 0);
    vecs[18] = mk(1, 20, 20, 120, 0, 0, 0,  1, 20, 20, 120, 1, 0, 0);
    vecs[19] = mk(1, 21, 21, 121, 0, 0, 0,  1, 20, 20, 120, 2, 0, 0);
    vecs[20] = mk(1, 22, 22, 122, 0, 0, 0,  1, 20, 20, 120, 3, 1, 0);
    vecs[21] = mk(1, 23, 23, 123, 0, 0, 0,  1, 20, 20, 120, 4, 1, 0);
    vecs[22] = mk(1, 99, 99, 199, 0, 0, 0,  1, 20, 20, 120, 4, 1, 1);
    vecs[23] = mk(0, 0,  0,  0,   1, 0, 0,  1, 21, 21, 121, 3, 1, 1);
    vecs[24] = mk(0, 0,  0,  0,   1, 0, 0,  1, 22, 22, 122, 2, 0, 1);
    vecs[25] = mk(0, 0,  0,  0,   1, 0, 0,  1, 23, 23, 123, 1, 0, 1);
    vecs[26] = mk(0, 0,  0,  0,   1, 0, 0,  0, 0,  0,  0,   0, 0, 1);
    vecs[27] = mk(0, 0,  0,  0,   0, 0, 1,  0, 0,  0,  0,   0, 0, 0);
    vecs[28] = mk(1, 30, 30, 130, 0, 0, 0,  1, 30, 30, 130, 1, 0, 0);
    vecs[29] = mk(1, 31, 31, 131, 0, 0, 0,  1, 30, 30, 130, 2, 0, 0);
    vecs[30] = mk(1, 32, 32, 132, 1, 1, 0,  0, 0,  0,  0,   0, 0, 0);
    vecs[31] = mk(0, 0,  0,  0,   1, 0, 0,  0, 0,  0,  0,   0, 0, 0);

    // reset
    apply(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 64'(bus.cdb_valid), 64'd0);
    check("reset.result", 64'(bus.cdb_result), 64'd0);
    check("reset.rob", 64'(bus.cdb_rob_entry), 64'd0);
    check("reset.dest", 64'(bus.cdb_dest_reg), 64'd0);
    check("reset.count", 64'(bus.count), 64'd0);
    check("reset.stall", 64'(bus.issue_stall), 64'd0);
    check("reset.overflow", 64'(bus.overflow), 64'd0);
    apply(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      wb_entry_t e;
      e.result = vecs[i].res; e.rob_entry = vecs[i].rob;
      e.dest_reg = vecs[i].dst;
      apply(vecs[i].fv, vecs[i].res, vecs[i].rob, vecs[i].dst, vecs[i].g,
            vecs[i].fl, vecs[i].rs);
      @(posedge clk);
      model_step(vecs[i].fv, e, vecs[i].g, vecs[i].fl, vecs[i].rs);
      #1;
      check($sformatf("vec%0d.valid", i), 64'(bus.cdb_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d.result", i), 64'(bus.cdb_result),
            64'(vecs[i].eres));
      check($sformatf("vec%0d.rob", i), 64'(bus.cdb_rob_entry),
            64'(vecs[i].erob));
      check($sformatf("vec%0d.dest", i), 64'(bus.cdb_dest_reg),
            64'(vecs[i].edst));
      check($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vecs[i].ecnt));
      check($sformatf("vec%0d.stall", i), 64'(bus.issue_stall),
            64'(vecs[i].est));
      check($sformatf("vec%0d.overflow", i), 64'(bus.overflow),
            64'(vecs[i].eov));
    end

    // wrap-around: ten back-to-back results streamed with grant held high
    for (int i = 0; i < 10; i++) begin
      drive_cycle($sformatf("wrap%0d", i), 1, 32'h100 + 32'(i), 8'(40 + i),
                  8'(200 + i), 1, 0, 0);
    end
    drive_cycle("wrap_drain0", 0, 0, 0, 0, 1, 0, 0);
    drive_cycle("wrap_drain1", 0, 0, 0, 0, 1, 0, 0);

    // overflow during flush is not an overflow; flush keeps sticky flag
    for (int i = 0; i < 4; i++) begin
      drive_cycle($sformatf("fill%0d", i), 1, 32'h200 + 32'(i), 8'(i),
                  8'(i), 0, 0, 0);
    end
    drive_cycle("full_flush_push", 1, 32'hdead, 8'h11, 8'h22, 0, 1, 0);
    drive_cycle("after_flush", 0, 0, 0, 0, 1, 0, 0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic fv;
      logic g;
      logic fl;
      logic rs;
      fv = ((model_q.size() < DEPTH - 1) && ($urandom_range(0, 9) < 7)) ||
           ($urandom_range(0, 29) == 0);
      g  = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 99) == 0);
      drive_cycle($sformatf("rand%0d", c), fv, $urandom, 8'($urandom),
                  8'($urandom), g, fl, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
